microwave_ctrl_param: RTL and testbench

//  Parametrised, single-clock microwave cook controller: keypad time entry, BCD countdown,

---
 rtl/microwave_ctrl_param_if.sv | 30 +++
 rtl/microwave_ctrl_param.sv | 195 +++++++++++++++++++
 tb/tb_microwave_ctrl_param.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_ctrl_param_if.sv
// Keypad/button/door inputs and display/magnetron outputs of the microwave cook controller.
// master = front panel side, slave = controller side.
interface microwave_ctrl_param_if #(
  parameter int MIN_DIGITS = 1,
  parameter int PWR_W      = 4
);
  localparam int DW = 4 * (MIN_DIGITS + 2);

  logic [9:0]       keypad;
  logic             startn;
  logic             stopn;
  logic             clearn;
  logic             door_closed;
  logic [PWR_W-1:0] power_lvl;
  logic [DW-1:0]    digits;
  logic             zero;
  logic             mag_on;
  logic             cooking;
  logic             beep;

  modport master (
    output keypad, startn, stopn, clearn, door_closed, power_lvl,
    input  digits, zero, mag_on, cooking, beep
  );

  modport slave (
    input  keypad, startn, stopn, clearn, door_closed, power_lvl,
    output digits, zero, mag_on, cooking, beep
  );
endinterface

// File: rtl/microwave_ctrl_param.sv
// Microwave cook controller: keypad entry, BCD countdown, door interlock, duty-cycled power.
// Optional end-of-cook beep with auto-return to IDLE is enabled by defining BEEP_EN.
module microwave_ctrl_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_DIGITS = 1,
  parameter int PWR_W      = 4,
  parameter int PWR_PERIOD = 10,
  parameter int BEEP_SECS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  microwave_ctrl_param_if.slave  bus
);
  localparam int ND  = MIN_DIGITS + 2;
  localparam int DW  = 4 * ND;
  localparam int PSW = $clog2(CLK_HZ);
  localparam logic [PSW-1:0]   PRESC_LAST = PSW'(CLK_HZ - 1);
  localparam logic [PWR_W-1:0] PERIOD_V   = PWR_W'(PWR_PERIOD);
  localparam logic [PWR_W-1:0] DUTY_LAST  = PWR_W'(PWR_PERIOD - 1);
  localparam logic [DW-1:0]    DIG_ONE    = DW'(1);

  if (CLK_HZ < 2 || PWR_PERIOD < 2 || BEEP_SECS < 1 || MIN_DIGITS < 1) begin : g_param_check
    $error("microwave_ctrl_param: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SET, COOK, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [PSW-1:0]   presc_q, presc_d;
  logic [PWR_W-1:0] duty_q, duty_d;
  logic [PWR_W-1:0] lvl_q, lvl_d;
  logic             key_prev_q, key_prev_d;
  logic             mag_q, mag_d;

  logic             key_one, key_accept, zero_w, run, run_d, tick, full_d;
  logic [3:0]       key_val;

`ifdef BEEP_EN
  localparam int BW = (BEEP_SECS < 2) ? 1 : $clog2(BEEP_SECS);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);
  logic          beep_q, beep_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
`endif

  // Seconds-tens digit wraps to 5, every other digit wraps to 9.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    logic [3:0]    nib;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      nib = v[4*i +: 4];
      if (borrow) begin
        if (nib == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = nib - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    key_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.keypad[i]) key_val = 4'(i);
    end
  end

  assign key_one    = $onehot(bus.keypad);
  assign key_accept = key_one & ~key_prev_q;
  assign zero_w     = (digits_q == '0);

`ifdef BEEP_EN
  assign run = (state_q == COOK) || (state_q == DONE && beep_q);
`else
  assign run = (state_q == COOK);
`endif
  assign tick = run && (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    duty_d     = duty_q;
    lvl_d      = lvl_q;
    key_prev_d = key_one;
`ifdef BEEP_EN
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
`endif

    // One event per cycle, highest priority first; a countdown tick only lands if nothing else did.
    if (!bus.clearn) begin
      state_d  = IDLE;
      digits_d = '0;
    end else if (!bus.stopn) begin
      if (state_q == COOK) begin
        state_d = PAUSE;
      end else if (state_q == SET || state_q == PAUSE) begin
        state_d  = IDLE;
        digits_d = '0;
      end
    end else if (!bus.door_closed && (state_q == COOK || state_q == DONE)) begin
      state_d = (state_q == COOK) ? PAUSE : IDLE;
    end else if (!bus.startn && bus.door_closed &&
                 (((state_q == SET || state_q == PAUSE) && !zero_w) || state_q == DONE)) begin
      if (state_q == DONE) begin
        state_d = IDLE;
      end else begin
        state_d = COOK;
        lvl_d   = bus.power_lvl;
        duty_d  = '0;
      end
    end else if (key_accept && (state_q == IDLE || state_q == SET || state_q == DONE)) begin
      if (state_q == DONE) begin
        state_d = IDLE;
      end else begin
        state_d  = SET;
        digits_d = {digits_q[DW-5:0], key_val};
      end
    end else if (state_q == COOK && tick) begin
      digits_d = bcd_dec(digits_q);
      duty_d   = (duty_q == DUTY_LAST) ? '0 : duty_q + 1'b1;
      if (digits_q == DIG_ONE) begin
        state_d = DONE;
`ifdef BEEP_EN
        beep_d     = 1'b1;
        beep_cnt_d = '0;
`endif
      end
    end
`ifdef BEEP_EN
    else if (state_q == DONE && beep_q && tick) begin
      if (beep_cnt_q == BEEP_LAST) begin
        state_d = IDLE;
      end else begin
        beep_cnt_d = beep_cnt_q + 1'b1;
      end
    end

    if (state_d != DONE) beep_d = 1'b0;
    run_d = (state_d == COOK) || (state_d == DONE && beep_d);
`else
    run_d = (state_d == COOK);
`endif

    // Only keep counting when running both now and next; any entry starts from a fresh second.
    presc_d = (run && run_d && !tick) ? presc_q + 1'b1 : '0;

    full_d = (lvl_d == '0) || (lvl_d >= PERIOD_V);
    mag_d  = (state_d == COOK) && (full_d || (duty_d < lvl_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      presc_q    <= '0;
      duty_q     <= '0;
      lvl_q      <= '0;
      key_prev_q <= 1'b0;
      mag_q      <= 1'b0;
`ifdef BEEP_EN
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      presc_q    <= presc_d;
      duty_q     <= duty_d;
      lvl_q      <= lvl_d;
      key_prev_q <= key_prev_d;
      mag_q      <= mag_d;
`ifdef BEEP_EN
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
`endif
    end
  end

  assign bus.digits  = digits_q;
  assign bus.zero    = zero_w;
  assign bus.mag_on  = mag_q & bus.door_closed;
  assign bus.cooking = (state_q == COOK);
`ifdef BEEP_EN
  assign bus.beep    = beep_q;
`else
  assign bus.beep    = 1'b0;
`endif
endmodule

// File: tb/tb_microwave_ctrl_param.sv
// Self-checking bench for microwave_ctrl_param; reference keeps the cook time as a decimal
// integer (mss) and derives expected digits/duty pattern arithmetically.
module tb_microwave_ctrl_param;
  localparam int CLK_HZ     = 4;
  localparam int MIN_DIGITS = 1;
  localparam int PWR_W      = 4;
  localparam int PWR_PERIOD = 4;
  localparam int BEEP_SECS  = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  microwave_ctrl_param_if #(.MIN_DIGITS(MIN_DIGITS), .PWR_W(PWR_W)) mw ();

  microwave_ctrl_param #(
    .CLK_HZ(CLK_HZ), .MIN_DIGITS(MIN_DIGITS), .PWR_W(PWR_W),
    .PWR_PERIOD(PWR_PERIOD), .BEEP_SECS(BEEP_SECS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mw)
  );

  // ---------------- reference model (decimal m:ss as an int) ----------------
  function automatic int ref_shift(input int v, input int k);
    return (v * 10 + k) % 1000;
  endfunction

  function automatic int ref_dec(input int v);
    if (v % 100 == 0) return v - 41;   // m:00 -> (m-1):59
    return v - 1;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int secs_left(input int v);
    int n = 0;
    int x = v;
    while (x > 0) begin
      x = ref_dec(x);
      n++;
    end
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    mw.keypad = 10'(1 << d);
    step();
    mw.keypad = '0;
    step();
  endtask

  task automatic start_pulse();
    mw.startn = 1'b0;
    step();
    mw.startn = 1'b1;
  endtask

  task automatic stop_pulse();
    mw.stopn = 1'b0;
    step();
    mw.stopn = 1'b1;
  endtask

  task automatic clear_pulse();
    mw.clearn = 1'b0;
    step();
    mw.clearn = 1'b1;
  endtask

  task automatic one_second();
    repeat (CLK_HZ) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst            = 1'b1;
    mw.keypad      = '0;
    mw.startn      = 1'b1;
    mw.stopn       = 1'b1;
    mw.clearn      = 1'b1;
    mw.door_closed = 1'b1;
    mw.power_lvl   = '0;
    repeat (2) step();
    checks++; if (mw.digits !== 12'h000) begin failures++; $display("FAIL reset_digits actual=%h required=000", mw.digits); end
    checks++; if (mw.zero !== 1'b1) begin failures++; $display("FAIL reset_zero actual=%b required=1", mw.zero); end
    checks++; if (mw.mag_on !== 1'b0) begin failures++; $display("FAIL reset_mag actual=%b required=0", mw.mag_on); end
    checks++; if (mw.cooking !== 1'b0) begin failures++; $display("FAIL reset_cooking actual=%b required=0", mw.cooking); end
    checks++; if (mw.beep !== 1'b0) begin failures++; $display("FAIL reset_beep actual=%b required=0", mw.beep); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_entry_example();
    press(1); press(3); press(0);
    checks++; if (mw.digits !== 12'h130) begin failures++; $display("FAIL entry_130 actual=%h required=130", mw.digits); end
    start_pulse();
    checks++; if (mw.cooking !== 1'b1) begin failures++; $display("FAIL entry_cooking actual=%b required=1", mw.cooking); end
    checks++; if (mw.digits !== 12'h130) begin failures++; $display("FAIL entry_start_digits actual=%h required=130", mw.digits); end
    one_second();
    checks++; if (mw.digits !== 12'h129) begin failures++; $display("FAIL entry_first_tick actual=%h required=129", mw.digits); end
    clear_pulse();
    checks++; if (mw.digits !== 12'h000 || mw.cooking !== 1'b0) begin failures++; $display("FAIL clear digits=%h cooking=%b required 000/0", mw.digits, mw.cooking); end
  endtask

  task automatic test_random_cook();
    for (int it = 0; it < 8; it++) begin
      int v = 0;
      int n;
      int run_secs;
      for (int k = 0; k < 3; k++) begin
        int key = $urandom_range(0, 9);
        press(key);
        v = ref_shift(v, key);
      end
      checks++; if (mw.digits !== to_bcd(v)) begin failures++; $display("FAIL rnd_entry actual=%h required=%h", mw.digits, to_bcd(v)); end
      mw.power_lvl = 4'($urandom_range(0, 15));
      start_pulse();
      if (v == 0) begin
        checks++; if (mw.cooking !== 1'b0) begin failures++; $display("FAIL rnd_zero_start actual=%b required=0", mw.cooking); end
      end else begin
        checks++; if (mw.cooking !== 1'b1) begin failures++; $display("FAIL rnd_start actual=%b required=1", mw.cooking); end
        n        = secs_left(v);
        run_secs = $urandom_range(0, (n > 5) ? 4 : n - 1);
        for (int s = 0; s < run_secs; s++) begin
          one_second();
          v = ref_dec(v);
          checks++; if (mw.digits !== to_bcd(v)) begin failures++; $display("FAIL rnd_count actual=%h required=%h", mw.digits, to_bcd(v)); end
        end
        stop_pulse();
        checks++; if (mw.cooking !== 1'b0 || mw.digits !== to_bcd(v)) begin failures++; $display("FAIL rnd_pause cooking=%b digits=%h required 0/%h", mw.cooking, mw.digits, to_bcd(v)); end
        stop_pulse();
        checks++; if (mw.digits !== 12'h000) begin failures++; $display("FAIL rnd_stop_idle actual=%h required=000", mw.digits); end
      end
      clear_pulse();
    end
  endtask

  task automatic test_boundaries();
    mw.power_lvl = '0;
    press(1); press(0); press(0);
    start_pulse();
    one_second();
    checks++; if (mw.digits !== to_bcd(ref_dec(100))) begin failures++; $display("FAIL min_borrow actual=%h required=%h", mw.digits, to_bcd(ref_dec(100))); end
    clear_pulse();

    press(0); press(0); press(1);
    start_pulse();
    checks++; if (mw.mag_on !== 1'b1) begin failures++; $display("FAIL last_sec_mag actual=%b required=1", mw.mag_on); end
    one_second();
    checks++; if (mw.zero !== 1'b1 || mw.digits !== 12'h000) begin failures++; $display("FAIL done_zero zero=%b digits=%h required 1/000", mw.zero, mw.digits); end
    checks++; if (mw.cooking !== 1'b0 || mw.mag_on !== 1'b0) begin failures++; $display("FAIL done_outputs cooking=%b mag=%b required 0/0", mw.cooking, mw.mag_on); end
`ifdef BEEP_EN
    for (int c = 0; c < BEEP_SECS * CLK_HZ; c++) begin
      checks++; if (mw.beep !== 1'b1) begin failures++; $display("FAIL beep_on cycle=%0d actual=%b required=1", c, mw.beep); end
      step();
    end
    checks++; if (mw.beep !== 1'b0) begin failures++; $display("FAIL beep_off actual=%b required=0", mw.beep); end
    press(5);
`else
    for (int c = 0; c < BEEP_SECS * CLK_HZ; c++) begin
      checks++; if (mw.beep !== 1'b0) begin failures++; $display("FAIL beep_tied cycle=%0d actual=%b required=0", c, mw.beep); end
      step();
    end
    press(7);
    checks++; if (mw.digits !== 12'h000) begin failures++; $display("FAIL done_exit_key actual=%h required=000", mw.digits); end
    press(5);
`endif
    checks++; if (mw.digits !== 12'h005) begin failures++; $display("FAIL after_done_entry actual=%h required=005", mw.digits); end
    clear_pulse();
  endtask

  task automatic test_door();
    mw.power_lvl = '0;
    press(2); press(0); press(0);
    start_pulse();
    repeat (2) step();
    checks++; if (mw.mag_on !== 1'b1) begin failures++; $display("FAIL door_mag_before actual=%b required=1", mw.mag_on); end
    mw.door_closed = 1'b0;
    #1;
    checks++; if (mw.mag_on !== 1'b0) begin failures++; $display("FAIL door_interlock actual=%b required=0", mw.mag_on); end
    step();
    checks++; if (mw.cooking !== 1'b0 || mw.digits !== 12'h200) begin failures++; $display("FAIL door_pause cooking=%b digits=%h required 0/200", mw.cooking, mw.digits); end
    mw.startn = 1'b0;
    step();
    checks++; if (mw.cooking !== 1'b0) begin failures++; $display("FAIL door_open_start actual=%b required=0", mw.cooking); end
    mw.startn      = 1'b1;
    mw.door_closed = 1'b1;
    start_pulse();
    checks++; if (mw.cooking !== 1'b1) begin failures++; $display("FAIL door_resume actual=%b required=1", mw.cooking); end
    one_second();
    checks++; if (mw.digits !== to_bcd(ref_dec(200))) begin failures++; $display("FAIL door_resume_count actual=%h required=%h", mw.digits, to_bcd(ref_dec(200))); end
    clear_pulse();
  endtask

  task automatic test_power();
    int lvls[4];
    lvls[0] = 1;
    lvls[1] = 0;
    lvls[2] = $urandom_range(2, PWR_PERIOD - 1);
    lvls[3] = $urandom_range(PWR_PERIOD, 15);
    for (int li = 0; li < 4; li++) begin
      int  lvl = lvls[li];
      logic exp_mag;
      press(1); press(0); press(0);
      mw.power_lvl = 4'(lvl);
      start_pulse();
      mw.power_lvl = 4'($urandom_range(0, 15));
      for (int c = 0; c < 2 * CLK_HZ * PWR_PERIOD; c++) begin
        exp_mag = (lvl == 0) || (lvl >= PWR_PERIOD) || (((c / CLK_HZ) % PWR_PERIOD) < lvl);
        checks++; if (mw.mag_on !== exp_mag) begin failures++; $display("FAIL duty lvl=%0d cycle=%0d actual=%b required=%b", lvl, c, mw.mag_on, exp_mag); end
        step();
      end
      clear_pulse();
    end
  endtask

  task automatic test_keypad_reject();
    press(4);
    checks++; if (mw.digits !== 12'h004) begin failures++; $display("FAIL key_single actual=%h required=004", mw.digits); end
    mw.keypad = 10'h003;
    step();
    mw.keypad = '0;
    step();
    checks++; if (mw.digits !== 12'h004) begin failures++; $display("FAIL key_multi actual=%h required=004", mw.digits); end
    mw.keypad = 10'(1 << 2);
    repeat (3) step();
    mw.keypad = '0;
    step();
    checks++; if (mw.digits !== 12'h042) begin failures++; $display("FAIL key_held actual=%h required=042", mw.digits); end
    clear_pulse();
    start_pulse();
    checks++; if (mw.cooking !== 1'b0) begin failures++; $display("FAIL start_idle_zero actual=%b required=0", mw.cooking); end
    press(0);
    start_pulse();
    checks++; if (mw.cooking !== 1'b0) begin failures++; $display("FAIL start_set_zero actual=%b required=0", mw.cooking); end
    clear_pulse();
  endtask

  task automatic test_back_to_back();
    press(3); press(0); press(0);
    start_pulse();
    step();
    mw.stopn  = 1'b0;
    mw.startn = 1'b0;
    step();
    mw.stopn  = 1'b1;
    mw.startn = 1'b1;
    checks++; if (mw.cooking !== 1'b0 || mw.digits !== 12'h300) begin failures++; $display("FAIL stop_wins cooking=%b digits=%h required 0/300", mw.cooking, mw.digits); end
    start_pulse();
    checks++; if (mw.cooking !== 1'b1) begin failures++; $display("FAIL pause_restart actual=%b required=1", mw.cooking); end
    clear_pulse();
  endtask

  task automatic test_reset_mid_cook();
    mw.power_lvl = '0;
    press(5); press(0); press(0);
    start_pulse();
    repeat (2) step();
    checks++; if (mw.mag_on !== 1'b1) begin failures++; $display("FAIL midrst_mag_before actual=%b required=1", mw.mag_on); end
    rst = 1'b1;
    #1;
    checks++; if (mw.mag_on !== 1'b0 || mw.cooking !== 1'b0) begin failures++; $display("FAIL midrst_async mag=%b cooking=%b required 0/0", mw.mag_on, mw.cooking); end
    checks++; if (mw.digits !== 12'h000 || mw.zero !== 1'b1) begin failures++; $display("FAIL midrst_digits digits=%h zero=%b required 000/1", mw.digits, mw.zero); end
    step();
    rst = 1'b0;
    step();
    checks++; if (mw.cooking !== 1'b0 || mw.beep !== 1'b0) begin failures++; $display("FAIL midrst_after cooking=%b beep=%b required 0/0", mw.cooking, mw.beep); end
  endtask

  initial begin
    test_reset();
    test_entry_example();
    test_random_cook();
    test_boundaries();
    test_door();
    test_power();
    test_keypad_reject();
    test_back_to_back();
    test_reset_mid_cook();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
